imem_loader: RTL and testbench
==============================

# imem_loader

Parametrised instruction-memory loader that sits between a word-stream source (host, UART bridge, boot ROM) and the single-cycle CPU's instruction-memory initialize port. It writes a programmed number of words to consecutive word-aligned byte addresses starting at a base address, and holds the CPU in reset until the load completes. It replaces hand-sequenced `initialize` / `instruction_initialize_*` driving with a handshaked, counted, optionally checksummed loader.

## Interface
- `DATA_W`, 32, instruction word width
- `ADDR_W`, 32, byte-address width of `instruction_initialize_address`
- `DEPTH`, 64, maximum words per load; `CNT_W = $clog2(DEPTH+1)`
- `BASE_ADDR`, 0, byte address of the first word (multiple of 4)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a load
- `word_count`  in  CNT_W  words to load; sampled when `start` is accepted
- `exp_sum`  in  DATA_W  expected checksum; sampled with `start`
- `s_valid`  in  1  source word valid
- `s_data`  in  DATA_W  source word
- `s_ready`  out  1  loader accepts word this cycle
- `initialize`  out  1  CPU instruction-memory initialize enable
- `instr_we`  out  1  one-cycle write strobe per word
- `instruction_initialize_data`  out  DATA_W  word to write
- `instruction_initialize_address`  out  ADDR_W  byte address of word
- `cpu_rst`  out  1  CPU reset hold
- `busy`  out  1  load in progress
- `done`  out  1  load complete, CPU released
- `error`  out  1  bad count or checksum mismatch
- `sum_ok`  out  1  checksum matched

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: `cpu_rst`=1, `initialize`=0, `s_ready`=0. On `start`: if `word_count`==0 or >DEPTH, set `error`, stay in IDLE; otherwise latch count and `exp_sum`, clear index, sum and `error`, and go to LOAD.
- LOAD: `busy`=1, `initialize`=1, `s_ready`=1. Each `s_valid && s_ready` is one transfer. It registers `s_data`, address `BASE_ADDR + 4*index` (mod 2^ADDR_W), and pulses `instr_we`. It also increments the index and adds the word to the sum. After the transfer with index == count-1, go to FLUSH; `s_ready` is 0 from that point.
- FLUSH: one cycle. The last word's `instr_we` is visible here with `initialize` still 1. Then go to DONE.
- DONE: `initialize`=0, `busy`=0. If the checksum passes, `cpu_rst`=0 and `done`=1. On mismatch, `cpu_rst` stays 1, `error`=1 and `done`=0. A new `start` re-enters IDLE's start evaluation in the same cycle.
- `start` in LOAD or FLUSH is ignored.
- Source stalls (`s_valid`=0) in LOAD: no write, no timeout, state held.
- Sum is modulo 2^DATA_W addition of accepted words.

## Timing
- Reset values: `cpu_rst`=1. All other outputs are 0, including data, address, `sum_ok`, `error`, `done` and `busy`. State is IDLE.
- `rst` in any state, including mid-LOAD, returns to IDLE next edge. Words already written are not retracted.
- `start` accepted at edge N means LOAD from N+1. `s_ready` is high in the cycle after `start`.
- Write latency: a transfer at edge k gives `instr_we`, data and address valid in cycle k+1 (one registered stage).
- Full-rate: N words with `s_valid` held high gives LOAD for N cycles, FLUSH for 1, DONE from N+2 after start acceptance.
- `error` from a bad count is asserted the cycle after `start` and held until the next accepted `start` or `rst`.
- Wrap-around: address arithmetic truncates to ADDR_W; index never exceeds DEPTH-1.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: sum accumulator and compare are built. `sum_ok` = (sum == latched `exp_sum`) in DONE. A mismatch holds `cpu_rst` and sets `error`.
- Not defined: no accumulator. `exp_sum` is ignored, `sum_ok` reads 1 in DONE (0 elsewhere), and DONE always releases `cpu_rst`.

## Test plan
- 7-word program (0x00020820 ADD, SUB, OR, SW, LW, 0x20220008 addi, 0x1000FFFF BEQ), `s_valid` constant, BASE_ADDR=0 -> writes at 0,4,…,24; `done` at cycle 9 after start; `cpu_rst` drops.
- Same program with `s_valid` toggled 1,0,0,1… -> identical address/data sequence and no extra `instr_we`; DONE is delayed by the gap count.
- `word_count`=0, then `word_count`=65 with DEPTH=64 -> `error`=1, stays IDLE, no `instr_we`, `cpu_rst`=1.
- `rst` after the third transfer -> next cycle IDLE with all outputs at reset values. A restart with 2 words writes addresses 0,4 only.
- Checksum enabled, `exp_sum` = true sum +1 -> DONE with `error`=1, `sum_ok`=0, `cpu_rst`=1. The correct sum gives `sum_ok`=1, `cpu_rst`=0.
- `start` pulsed mid-LOAD, and BASE_ADDR=0xFFFFFFF8 with 3 words -> pulse ignored; addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a counted program into the CPU's imem
// initialize port and holds the CPU in reset until the load completes.
// Optional checksum compare is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               CNT_W     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [DATA_W-1:0] exp_sum,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              initialize,
  output logic              instr_we,
  output logic [DATA_W-1:0] instruction_initialize_data,
  output logic [ADDR_W-1:0] instruction_initialize_address,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              sum_ok
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt_q, idx_q;
  logic              err_q, we_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              xfer, last, cnt_bad, start_eval, match;

  assign s_ready    = (state == LOAD);
  assign xfer       = s_valid && s_ready;
  assign last       = (idx_q == cnt_q - 1'b1);
  assign cnt_bad    = (word_count == '0) || (word_count > CNT_W'(DEPTH));
  assign start_eval = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = cnt_bad ? IDLE : LOAD;
      LOAD:       if (xfer && last) state_nx = FLUSH;
      FLUSH:      state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nx;
      we_q  <= xfer;
      if (start_eval) begin
        err_q <= cnt_bad;
        if (!cnt_bad) begin
          cnt_q <= word_count;
          idx_q <= '0;
        end
      end
      if (xfer) begin
        data_q <= s_data;
        addr_q <= BASE_ADDR + (ADDR_W'(idx_q) << 2);
        // index stops at count-1 so it never reaches DEPTH
        if (!last) idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      exp_q <= '0;
    end else if (start_eval && !cnt_bad) begin
      sum_q <= '0;
      exp_q <= exp_sum;
    end else if (xfer) begin
      sum_q <= sum_q + s_data;
    end
  end

  assign match = (sum_q == exp_q);
`else
  logic [DATA_W-1:0] unused_exp_sum;
  assign unused_exp_sum = exp_sum;
  assign match          = 1'b1;
`endif

  assign initialize                     = (state == LOAD) || (state == FLUSH);
  assign busy                           = initialize;
  assign done                           = (state == DONE) && match;
  assign sum_ok                         = done;
  assign cpu_rst                        = !done;
  assign error                          = err_q || ((state == DONE) && !match);
  assign instr_we                       = we_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0 and base 0xFFFFFFF8)
// share stimulus; monitors pop expected {addr,data} on every write strobe.
module tb_imem_loader;
  localparam int DW = 32, AW = 32, DEPTH = 64, CW = 7;
  localparam logic [31:0] SUM7 = 32'h68B24076;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic [DW-1:0] exp_sum = '0, s_data = '0;

  logic          s_ready, initialize, instr_we, cpu_rst, busy, done, error, sum_ok;
  logic [DW-1:0] ii_data;
  logic [AW-1:0] ii_addr;
  logic          w_s_ready, w_initialize, w_instr_we, w_cpu_rst, w_busy, w_done, w_error, w_sum_ok;
  logic [DW-1:0] w_data;
  logic [AW-1:0] w_addr;

  logic [31:0] prog [0:6];
  logic [63:0] q[$], qw[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  imem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .exp_sum(exp_sum),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .initialize(initialize),
    .instr_we(instr_we), .instruction_initialize_data(ii_data),
    .instruction_initialize_address(ii_addr), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .error(error), .sum_ok(sum_ok));

  imem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .exp_sum(exp_sum),
    .s_valid(s_valid), .s_data(s_data), .s_ready(w_s_ready), .initialize(w_initialize),
    .instr_we(w_instr_we), .instruction_initialize_data(w_data),
    .instruction_initialize_address(w_addr), .cpu_rst(w_cpu_rst), .busy(w_busy),
    .done(w_done), .error(w_error), .sum_ok(w_sum_ok));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i);
    q.push_back({32'(4 * i), prog[i]});
    qw.push_back({32'hFFFF_FFF8 + 32'(4 * i), prog[i]});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_initialize"}, initialize, 0);
    chk({tag, "_instr_we"}, instr_we, 0);
    chk({tag, "_data"}, ii_data, 0);
    chk({tag, "_addr"}, ii_addr, 0);
    chk({tag, "_wrap_addr"}, w_addr, 0);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_sum_ok"}, sum_ok, 0);
  endtask

  // gaps: source valid only every third cycle; pulse: start mid-LOAD
  task automatic load(input string tag, input int n, input logic [31:0] esum, input bit gaps,
                      input bit pulse, input int exp_cyc, input bit exp_ok);
    int cyc, i;
    start = 1'b1; word_count = CW'(n); exp_sum = esum;
    tick;
    start = 1'b0; cyc = 1; i = 0;
    chk({tag, "_s_ready_after_start"}, s_ready, 1);
    chk({tag, "_error_cleared"}, error, 0);
    while (i < n && cyc < 200) begin
      s_valid = !gaps || ((cyc - 1) % 3 == 0);
      s_data  = prog[i];
      start   = pulse && (cyc == 2);
      if (pulse) word_count = CW'(1);
      if (s_valid) push(i);
      tick;
      cyc++;
      if (s_valid) i++;
    end
    s_valid = 1'b0; start = 1'b0;
    chk({tag, "_flush_initialize"}, initialize, 1);
    chk({tag, "_flush_s_ready"}, s_ready, 0);
    while (!(done || error) && cyc < 250) begin
      tick;
      cyc++;
    end
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_done"}, done, exp_ok);
    chk({tag, "_sum_ok"}, sum_ok, exp_ok);
    chk({tag, "_cpu_rst"}, cpu_rst, !exp_ok);
    chk({tag, "_error"}, error, !exp_ok);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_initialize_off"}, initialize, 0);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (instr_we) begin
      if (q.size() == 0) chk("unexpected_we", {ii_addr, ii_data}, 64'h0);
      else begin
        e = q.pop_front();
        chk("write_addr_data", {ii_addr, ii_data}, e);
      end
      chk("we_with_initialize", initialize, 1);
    end
    if (w_instr_we) begin
      if (qw.size() == 0) chk("wrap_unexpected_we", {w_addr, w_data}, 64'h0);
      else begin
        e = qw.pop_front();
        chk("wrap_addr_data", {w_addr, w_data}, e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ck_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_ok = 1'b0;
`else
    ck_ok = 1'b1;
`endif
    prog[0] = 32'h00020820; prog[1] = 32'h00221822; prog[2] = 32'h00622025;
    prog[3] = 32'hAC040004; prog[4] = 32'h8C050004; prog[5] = 32'h20220008;
    prog[6] = 32'h1000FFFF;

    tick; tick;
    chk_reset_vals("in_reset");
    rst = 1'b0;
    tick;
    chk_reset_vals("idle");

    load("full7", 7, SUM7, 0, 0, 9, 1);
    load("stall7", 7, SUM7, 1, 0, 21, 1);

    // bad counts: zero and above DEPTH
    word_count = CW'(0); start = 1'b1; tick; start = 1'b0;
    chk("cnt0_error", error, 1);
    chk("cnt0_cpu_rst", cpu_rst, 1);
    chk("cnt0_s_ready", s_ready, 0);
    tick; tick;
    chk("cnt0_error_held", error, 1);
    chk("cnt0_busy", busy, 0);
    word_count = CW'(65); start = 1'b1; tick; start = 1'b0;
    chk("cnt65_error", error, 1);
    chk("cnt65_s_ready", s_ready, 0);
    tick;
    chk("cnt65_cpu_rst", cpu_rst, 1);

    // reset after the third transfer
    word_count = CW'(7); exp_sum = SUM7; start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = prog[i]; push(i); tick;
    end
    s_valid = 1'b0; rst = 1'b1; tick; rst = 1'b0;
    chk_reset_vals("mid_rst");
    load("restart2", 2, 32'h00242042, 0, 0, 4, 1);

    load("bad_sum", 7, SUM7 + 32'd1, 0, 0, 9, ck_ok);
    load("good_sum", 7, SUM7, 0, 0, 9, 1);
    load("pulse3", 3, 32'h00864067, 0, 1, 5, 1);

    tick; tick;
    chk("queue_drained", 64'(q.size()), 0);
    chk("wrap_queue_drained", 64'(qw.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
